// File: rtl/ibex_instr_bus_pkg.sv
// Shared types for the ibex instruction-fetch responder: capability layout,
// grant FSM encoding and the response pipeline stage record.
package ibex_instr_bus_pkg;

  localparam int unsigned CAP_W       = 93;
  localparam int unsigned CAP_TAG_BIT = 93;

  typedef enum logic [0:0] {
    GNT_IDLE  = 1'b0,
    GNT_STALL = 1'b1
  } gnt_state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_stage_t;

endpackage

// File: rtl/ibex_instr_bus_responder_if.sv
// Instruction-fetch bus (req/gnt/rvalid) between the prefetch buffer (master)
// and the instruction memory responder (slave).
interface ibex_instr_bus_responder_if;
  import ibex_instr_bus_pkg::*;

  logic           instr_req;
  logic           instr_gnt;
  logic [31:0]    instr_addr;
  logic [CAP_W:0] instr_cap;
  logic           instr_rvalid;
  logic [31:0]    instr_rdata;
  logic           instr_err;

  modport master (
    output instr_req, instr_addr, instr_cap,
    input  instr_gnt, instr_rvalid, instr_rdata, instr_err
  );

  modport slave (
    input  instr_req, instr_addr, instr_cap,
    output instr_gnt, instr_rvalid, instr_rdata, instr_err
  );

endinterface

// File: rtl/ibex_instr_rsp_pipe.sv
// LATENCY-stage response shift register: stage 0 records {valid, err} at the
// grant, stage 1 folds in the SRAM read data, later stages copy it forward.
module ibex_instr_rsp_pipe
  import ibex_instr_bus_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic        in_err_i,
  input  logic [31:0] mem_rdata_i,
  output logic        out_valid_o,
  output logic        out_err_o,
  output logic [31:0] out_rdata_o
);

  rsp_stage_t  stage_q [LATENCY];
  rsp_stage_t  stage_d [LATENCY];
  logic [31:0] fetched;

  // SRAM data lands one cycle after the grant, i.e. while stage 0 holds it.
  assign fetched = (stage_q[0].valid && !stage_q[0].err) ? mem_rdata_i : 32'h0;

  always_comb begin
    // NOTE: every element gets a value on every path so no latch is inferred.
    for (int i = 0; i < LATENCY; i++) begin
      stage_d[i] = '0;
    end
    stage_d[0].valid = in_valid_i;
    stage_d[0].err   = in_valid_i && in_err_i;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
      if (i == 1) begin
        stage_d[i].rdata = fetched;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the whole stage (data too) is reset so rdata reads 0 during reset.
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every stage shifts from its pre-edge neighbour.
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  if (LATENCY == 1) begin : g_single
    assign out_valid_o = stage_q[0].valid;
    assign out_err_o   = stage_q[0].err;
    assign out_rdata_o = fetched;
  end else begin : g_multi
    assign out_valid_o = stage_q[LATENCY-1].valid;
    assign out_err_o   = stage_q[LATENCY-1].err;
    assign out_rdata_o = stage_q[LATENCY-1].rdata;
  end

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Instruction memory responder: stalls grants, limits outstanding fetches,
// range/tag checks each grant and returns in-order responses after LATENCY.
module ibex_instr_bus_responder
  import ibex_instr_bus_pkg::*;
#(
  parameter int unsigned MEM_AW          = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  ibex_instr_bus_responder_if.slave   bus,
  output logic                        mem_req_o,
  output logic [MEM_AW-1:0]           mem_addr_o,
  input  logic [31:0]                 mem_rdata_i
);

  localparam logic [0:0]  IDLE       = 1'(GNT_IDLE);
  localparam logic [0:0]  STALL      = 1'(GNT_STALL);
  localparam logic [2:0]  STALL_INIT = 3'((GNT_DELAY == 0) ? 0 : GNT_DELAY - 1);
  localparam logic [2:0]  MAX_OUT    = 3'(MAX_OUTSTANDING);
  localparam logic [30:0] MEM_WORDS  = 31'(1) << MEM_AW;

  logic [0:0]  state_q, state_d;
  logic [2:0]  stall_cnt_q, stall_cnt_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic        gnt_fsm, gnt, can_accept;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [30:0] word_off;
  logic        in_range, acc_err;

  // Word offset computed one bit wider so addresses below BASE_ADDR don't wrap.
  assign word_off = {1'b0, bus.instr_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign in_range = (bus.instr_addr >= BASE_ADDR) && (word_off < MEM_WORDS);
  assign acc_err  = !in_range || !bus.instr_cap[CAP_TAG_BIT];

  // A response leaving this cycle frees its slot for a same-cycle grant.
  assign can_accept = (outstanding_q < MAX_OUT) || rsp_valid;

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    gnt_fsm     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instr_req && can_accept) begin
          if (GNT_DELAY == 0) begin
            gnt_fsm = 1'b1;
          end else begin
            state_d     = STALL;
            stall_cnt_d = STALL_INIT;
          end
        end
      end
      STALL: begin
        if (!bus.instr_req) begin
          state_d = IDLE;
        end else if (stall_cnt_q != 3'd0) begin
          stall_cnt_d = stall_cnt_q - 3'd1;
        end else if (can_accept) begin
          gnt_fsm = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The zero-delay grant is combinational from req, so hold it low in reset.
  assign gnt           = gnt_fsm && rst_ni;
  assign outstanding_d = outstanding_q + 3'(gnt) - 3'(rsp_valid);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      stall_cnt_q   <= 3'd0;
      outstanding_q <= 3'd0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign mem_req_o  = gnt && !acc_err;
  assign mem_addr_o = word_off[MEM_AW-1:0];

  ibex_instr_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_rsp_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (gnt),
    .in_err_i    (acc_err),
    .mem_rdata_i (mem_rdata_i),
    .out_valid_o (rsp_valid),
    .out_err_o   (rsp_err),
    .out_rdata_o (rsp_rdata)
  );

  assign bus.instr_gnt    = gnt;
  assign bus.instr_rvalid = rsp_valid;
  assign bus.instr_err    = rsp_err;
  assign bus.instr_rdata  = rsp_rdata;

  a_gnt_needs_req : assert property (
    @(posedge clk_i) disable iff (!rst_ni) gnt |-> bus.instr_req);
  a_outstanding_max : assert property (
    @(posedge clk_i) disable iff (!rst_ni) outstanding_q <= MAX_OUT);
  a_rvalid_after_gnt : assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsp_valid |-> (outstanding_q != 3'd0));

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Directed bench: three responder configurations sharing clock/reset, each
// backed by a behavioural synchronous SRAM with a fixed word pattern.
module tb_ibex_instr_bus_responder;
  import ibex_instr_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  ibex_instr_bus_responder_if bus_a ();
  ibex_instr_bus_responder_if bus_b ();
  ibex_instr_bus_responder_if bus_c ();

  logic       mem_req_a, mem_req_b, mem_req_c;
  logic [9:0] mem_addr_a, mem_addr_b, mem_addr_c;
  logic [31:0] mem_rdata_a, mem_rdata_b, mem_rdata_c;

  // a: no stall, latency 1; b: 2-cycle stall, latency 1; c: no stall, latency 3
  ibex_instr_bus_responder #(.MEM_AW(10), .BASE_ADDR(32'h0), .GNT_DELAY(0),
                             .LATENCY(1), .MAX_OUTSTANDING(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_a),
    .mem_req_o(mem_req_a), .mem_addr_o(mem_addr_a), .mem_rdata_i(mem_rdata_a));

  ibex_instr_bus_responder #(.MEM_AW(10), .BASE_ADDR(32'h0), .GNT_DELAY(2),
                             .LATENCY(1), .MAX_OUTSTANDING(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_b),
    .mem_req_o(mem_req_b), .mem_addr_o(mem_addr_b), .mem_rdata_i(mem_rdata_b));

  ibex_instr_bus_responder #(.MEM_AW(10), .BASE_ADDR(32'h0), .GNT_DELAY(0),
                             .LATENCY(3), .MAX_OUTSTANDING(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_c),
    .mem_req_o(mem_req_c), .mem_addr_o(mem_addr_c), .mem_rdata_i(mem_rdata_c));

  function automatic logic [31:0] sram_word(input logic [9:0] a);
    return (a == 10'd0) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {22'd0, a});
  endfunction

  always_ff @(posedge clk) begin
    if (mem_req_a) mem_rdata_a <= sram_word(mem_addr_a);
    if (mem_req_b) mem_rdata_b <= sram_word(mem_addr_b);
    if (mem_req_c) mem_rdata_c <= sram_word(mem_addr_c);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [CAP_W:0] cap_ok;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cap_ok = '0;
    cap_ok[CAP_TAG_BIT] = 1'b1;
    rst_n = 1'b0;
    bus_a.instr_req = 1'b0; bus_a.instr_addr = 32'h0; bus_a.instr_cap = '0;
    bus_b.instr_req = 1'b0; bus_b.instr_addr = 32'h0; bus_b.instr_cap = '0;
    bus_c.instr_req = 1'b0; bus_c.instr_addr = 32'h0; bus_c.instr_cap = '0;
    mem_rdata_a = 32'h0; mem_rdata_b = 32'h0; mem_rdata_c = 32'h0;

    // Reset state
    #2;
    check("rst_gnt_a",    32'(bus_a.instr_gnt),    32'h0);
    check("rst_rvalid_a", 32'(bus_a.instr_rvalid), 32'h0);
    check("rst_err_a",    32'(bus_a.instr_err),    32'h0);
    check("rst_rdata_a",  bus_a.instr_rdata,       32'h0);
    check("rst_memreq_a", 32'(mem_req_a),          32'h0);
    check("rst_rvalid_c", 32'(bus_c.instr_rvalid), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    // Zero-delay grant, latency 1
    bus_a.instr_req = 1'b1; bus_a.instr_addr = 32'h0; bus_a.instr_cap = cap_ok;
    @(negedge clk);
    check("t1_gnt",     32'(bus_a.instr_gnt),    32'h1);
    check("t1_memreq",  32'(mem_req_a),          32'h1);
    check("t1_memaddr", 32'(mem_addr_a),         32'h0);
    check("t1_rvalid0", 32'(bus_a.instr_rvalid), 32'h0);
    next_cycle();
    bus_a.instr_req = 1'b0;
    @(negedge clk);
    check("t1_rvalid",  32'(bus_a.instr_rvalid), 32'h1);
    check("t1_rdata",   bus_a.instr_rdata,       32'hDEAD_BEEF);
    check("t1_err",     32'(bus_a.instr_err),    32'h0);
    check("t1_gnt_off", 32'(bus_a.instr_gnt),    32'h0);
    next_cycle();
    @(negedge clk);
    check("t1_rvalid_off", 32'(bus_a.instr_rvalid), 32'h0);
    next_cycle();

    // Two-cycle stall; address changes mid-stall, value at grant is used
    bus_b.instr_req = 1'b1; bus_b.instr_addr = 32'h4; bus_b.instr_cap = cap_ok;
    @(negedge clk);
    check("t2_gnt_c0", 32'(bus_b.instr_gnt), 32'h0);
    next_cycle();
    bus_b.instr_addr = 32'h8;
    @(negedge clk);
    check("t2_gnt_c1", 32'(bus_b.instr_gnt), 32'h0);
    next_cycle();
    @(negedge clk);
    check("t2_gnt_c2",   32'(bus_b.instr_gnt), 32'h1);
    check("t2_memaddr",  32'(mem_addr_b),      32'h2);
    check("t2_memreq",   32'(mem_req_b),       32'h1);
    next_cycle();
    bus_b.instr_req = 1'b0;
    @(negedge clk);
    check("t2_rvalid", 32'(bus_b.instr_rvalid), 32'h1);
    check("t2_rdata",  bus_b.instr_rdata,       32'hC0DE_0002);
    check("t2_err",    32'(bus_b.instr_err),    32'h0);
    next_cycle();

    // Latency 3 with two outstanding: third grant waits for first rvalid
    bus_c.instr_req = 1'b1; bus_c.instr_addr = 32'h0; bus_c.instr_cap = cap_ok;
    @(negedge clk);
    check("t3_gnt_t0", 32'(bus_c.instr_gnt), 32'h1);
    next_cycle();
    bus_c.instr_addr = 32'h4;
    @(negedge clk);
    check("t3_gnt_t1", 32'(bus_c.instr_gnt), 32'h1);
    next_cycle();
    bus_c.instr_addr = 32'h8;
    @(negedge clk);
    check("t3_gnt_t2",    32'(bus_c.instr_gnt),    32'h0);
    check("t3_rvalid_t2", 32'(bus_c.instr_rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    check("t3_rvalid_t3",  32'(bus_c.instr_rvalid), 32'h1);
    check("t3_rdata_t3",   bus_c.instr_rdata,       32'hDEAD_BEEF);
    check("t3_gnt_t3",     32'(bus_c.instr_gnt),    32'h1);
    check("t3_memaddr_t3", 32'(mem_addr_c),         32'h2);
    next_cycle();
    bus_c.instr_req = 1'b0;
    @(negedge clk);
    check("t3_rvalid_t4", 32'(bus_c.instr_rvalid), 32'h1);
    check("t3_rdata_t4",  bus_c.instr_rdata,       32'hC0DE_0001);
    next_cycle();
    @(negedge clk);
    check("t3_rvalid_t5", 32'(bus_c.instr_rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    check("t3_rvalid_t6", 32'(bus_c.instr_rvalid), 32'h1);
    check("t3_rdata_t6",  bus_c.instr_rdata,       32'hC0DE_0002);
    check("t3_err_t6",    32'(bus_c.instr_err),    32'h0);
    next_cycle();

    // Access errors: just past the top of SRAM, last word, untagged cap
    bus_a.instr_req = 1'b1; bus_a.instr_addr = 32'h0000_1000; bus_a.instr_cap = cap_ok;
    @(negedge clk);
    check("t4_oor_gnt",    32'(bus_a.instr_gnt), 32'h1);
    check("t4_oor_memreq", 32'(mem_req_a),       32'h0);
    next_cycle();
    bus_a.instr_req = 1'b0;
    @(negedge clk);
    check("t4_oor_rvalid", 32'(bus_a.instr_rvalid), 32'h1);
    check("t4_oor_err",    32'(bus_a.instr_err),    32'h1);
    check("t4_oor_rdata",  bus_a.instr_rdata,       32'h0);
    next_cycle();
    bus_a.instr_req = 1'b1; bus_a.instr_addr = 32'h0000_0FFC;
    @(negedge clk);
    check("t4_top_memreq",  32'(mem_req_a),  32'h1);
    check("t4_top_memaddr", 32'(mem_addr_a), 32'h3FF);
    next_cycle();
    bus_a.instr_req = 1'b0;
    @(negedge clk);
    check("t4_top_err",   32'(bus_a.instr_err), 32'h0);
    check("t4_top_rdata", bus_a.instr_rdata,    32'hC0DE_03FF);
    next_cycle();
    bus_a.instr_req = 1'b1; bus_a.instr_addr = 32'h0; bus_a.instr_cap = '0;
    @(negedge clk);
    check("t4_tag_gnt",    32'(bus_a.instr_gnt), 32'h1);
    check("t4_tag_memreq", 32'(mem_req_a),       32'h0);
    next_cycle();
    bus_a.instr_req = 1'b0;
    @(negedge clk);
    check("t4_tag_rvalid", 32'(bus_a.instr_rvalid), 32'h1);
    check("t4_tag_err",    32'(bus_a.instr_err),    32'h1);
    check("t4_tag_rdata",  bus_a.instr_rdata,       32'h0);
    next_cycle();

    // Abandoned fetch still answered; reset drops the next in-flight one
    bus_c.instr_req = 1'b1; bus_c.instr_addr = 32'h10; bus_c.instr_cap = cap_ok;
    @(negedge clk);
    check("t5_gnt", 32'(bus_c.instr_gnt), 32'h1);
    next_cycle();
    bus_c.instr_req = 1'b0;
    @(negedge clk);
    check("t5_rvalid_t1", 32'(bus_c.instr_rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    check("t5_rvalid_t2", 32'(bus_c.instr_rvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    check("t5_rvalid_t3", 32'(bus_c.instr_rvalid), 32'h1);
    check("t5_rdata_t3",  bus_c.instr_rdata,       32'hC0DE_0004);
    next_cycle();
    bus_c.instr_req = 1'b1; bus_c.instr_addr = 32'h14;
    @(negedge clk);
    check("t5_gnt2", 32'(bus_c.instr_gnt), 32'h1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_gnt",    32'(bus_c.instr_gnt),    32'h0);
    check("t5_rst_rvalid", 32'(bus_c.instr_rvalid), 32'h0);
    check("t5_rst_err",    32'(bus_c.instr_err),    32'h0);
    check("t5_rst_rdata",  bus_c.instr_rdata,       32'h0);
    check("t5_rst_memreq", 32'(mem_req_c),          32'h0);
    next_cycle();
    bus_c.instr_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_post_rst_rvalid", 32'(bus_c.instr_rvalid), 32'h0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_instr_bus_responder.md
Name: ibex_instr_bus_responder

Overview:
Responder (slave) end of the ibex instruction-fetch bus (req/gnt/rvalid), driven by the prefetch buffer.
- Grants requests after a configurable stall.
- Reads a word-addressed synchronous SRAM backend.
- Returns rdata with a fixed configurable latency.
- Flags out-of-range or untagged capability fetches.
- Used as the instruction memory in core-level benches and FPGA top.

Parameters:
MEM_AW, 10, SRAM word-address width (depth 2**MEM_AW words)
BASE_ADDR, 32'h0000_0000, byte address of SRAM word 0; must be 4-byte aligned
GNT_DELAY, 0, cycles req must be held before gnt (0..7)
LATENCY, 1, cycles from gnt to rvalid (1..4)
MAX_OUTSTANDING, 2, max granted-but-unanswered requests (1..LATENCY)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  request accepted this cycle
instr_addr_i  in  32  byte address, word aligned (bits [1:0] ignored)
instr_cap_i  in  94  fetch capability; bit 93 = valid tag
instr_rvalid_o  out  1  response valid
instr_rdata_o  out  32  response data
instr_err_o  out  1  response error, qualified by rvalid
mem_req_o  out  1  SRAM read enable
mem_addr_o  out  MEM_AW  SRAM word address
mem_rdata_i  in  32  SRAM data, valid one cycle after mem_req_o

Behaviour:
- Reset state: gnt/rvalid/err/mem_req = 0; rdata = 0; counters = 0; FSM = IDLE.
- Reset mid-operation: all in-flight responses are dropped; no rvalid after reset.

Grant FSM, states IDLE and STALL:
- IDLE, req=1, can_accept=1:
  - GNT_DELAY=0: gnt=1 combinationally, stay IDLE.
  - Otherwise: load stall_cnt=GNT_DELAY-1 and go to STALL.
- STALL:
  - req=0: return to IDLE, no grant. Withdrawal is legal.
  - stall_cnt>0: decrement.
  - stall_cnt==0 and can_accept: gnt=1, go to IDLE.
- An address or cap change while waiting does not restart the stall. Only the values at the gnt cycle are used.

Outstanding limit:
- can_accept = (outstanding < MAX_OUTSTANDING) || rvalid_this_cycle.
- outstanding counts +1 on gnt and -1 on rvalid; both in one cycle leaves it unchanged.

Access check, evaluated at the gnt cycle:
- word = (instr_addr_i - BASE_ADDR) >> 2.
- in_range = instr_addr_i >= BASE_ADDR && word < 2**MEM_AW. Use 33-bit compare so there is no wrap on the subtraction.
- err = !in_range || !instr_cap_i[93].
- mem_req_o = gnt && !err; mem_addr_o = word[MEM_AW-1:0].

Response pipeline:
- Shift register of LATENCY stages, each holding {valid, err}.
- Stage 0 captures at the gnt cycle.
- Data path: stage 1 captures mem_rdata_i, or 0 if err; stages 2..LATENCY copy forward.
- Outputs are driven from the final stage registers, so rvalid is asserted exactly LATENCY cycles after gnt, in order.
- Erroring responses return rdata=0 and err=1.
- Every granted request receives exactly one rvalid, including requests the initiator has abandoned after a branch. The initiator relies on this (WAIT_ABORTED).
- Back-to-back grants are allowed every cycle, up to the MAX_OUTSTANDING limit.
- rvalid has no ready signal; the initiator must accept it.

Assertions:
- gnt only when req=1.
- outstanding never exceeds MAX_OUTSTANDING.
- No rvalid without a prior grant.

Decomposition:
- Shared package ibex_instr_bus_pkg holds:
  - CAP_W = 93 and CAP_TAG_BIT = 93;
  - the grant FSM enum {IDLE, STALL};
  - the response stage struct {valid, err, rdata}.
- One sub-module, ibex_instr_rsp_pipe: a parameterised LATENCY-stage valid/err/data shift register with async reset.
- The grant FSM, range check and counters stay in the top module.

Test Plan:
- GNT_DELAY=0, LATENCY=1, SRAM[0]=32'hDEAD_BEEF; req addr 0x0, tagged cap -> gnt same cycle; rvalid, rdata=DEADBEEF, err=0 next cycle.
- GNT_DELAY=2; req held at 0x4 with addr changed to 0x8 after 1 cycle -> gnt on 3rd cycle, SRAM word 2 returned.
- LATENCY=3, MAX_OUTSTANDING=2; req held continuously at 0x0, 0x4, 0x8 -> gnts at t0 and t1; third gnt stalls until t3 (first rvalid); responses in order at t3, t4, t6.
- Addr 0x0000_1000 with MEM_AW=10, and separately addr 0x0 with cap bit 93 = 0 -> gnt; mem_req_o=0; rvalid with err=1, rdata=0.
- Grant at 0x10, req dropped next cycle (branch abort), then rst_ni pulsed low during a second in-flight request -> first rvalid still delivered; no rvalid after reset; all outputs 0 during reset.
